// File: rtl/decode_hazard_scoreboard_pkg.sv
// Shared types for the decode hazard scoreboard: register address, latency class
// and the counter value that marks an outstanding divide.
package decode_hazard_scoreboard_pkg;

  typedef logic [4:0] creg_addr_t;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2,
    LAT_DIV  = 2'd3
  } lat_class_t;

  // Counter value meaning "waiting on the divider"; only div_done clears it.
  localparam logic [2:0] CNT_DIV_SENTINEL = 3'd7;

endpackage

// File: rtl/decode_hazard_scoreboard_cnt_cell.sv
// One register's cycles-until-forwardable counter: load on issue, clear on
// divide completion, otherwise count down unless the backend is frozen.
module hazard_cnt_cell
  import decode_hazard_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       clear,
  output logic [2:0] cnt
);

  // A new issue beats a same-edge divide clear so the newest producer wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clear) begin
      cnt <= 3'd0;
    end else if (!hold && cnt != 3'd0 && cnt != CNT_DIV_SENTINEL) begin
      cnt <= cnt - 3'd1;
    end
  end

endmodule

// File: rtl/decode_hazard_scoreboard.sv
// Decode-stage hazard controller: stalls decode until every used source is on the
// forward bus; optional stall statistics when HAZARD_STATS_EN is defined.
module decode_hazard_scoreboard
  import decode_hazard_scoreboard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2,
  parameter int NREG     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_use1,
  input  logic [4:0]  id_src1,
  input  logic        id_use2,
  input  logic [4:0]  id_src2,
  input  logic        id_wen,
  input  logic [4:0]  id_dst,
  input  logic [1:0]  id_lat,
  input  logic        pipe_hold,
  input  logic        id_flush,
  input  logic        div_done,
  output logic        id_stall,
  output logic        id_issue,
  output logic        div_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  logic [2:0] cnt [32];
  creg_addr_t div_dst;
  lat_class_t lat;
  logic [2:0] issue_val;
  logic       haz;
  logic       wr_en;
  logic       div_clr;

  assign lat     = lat_class_t'(id_lat);
  assign div_clr = div_done & div_busy;
  assign wr_en   = id_issue & id_wen & (id_dst != 5'd0);

  always_comb begin
    issue_val = 3'd0;
    case (lat)
      LAT_ALU:  issue_val = 3'd0;
      LAT_LOAD: issue_val = 3'(LOAD_LAT);
      LAT_MUL:  issue_val = 3'(MUL_LAT);
      LAT_DIV:  issue_val = CNT_DIV_SENTINEL;
      default:  issue_val = 3'd0;
    endcase
  end

  assign cnt[0] = 3'd0;

  for (genvar r = 1; r < 32; r++) begin : g_cell
    if (r < NREG) begin : g_tracked
      hazard_cnt_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .hold     (pipe_hold),
        .load     (wr_en && id_dst == 5'(r)),
        .load_val (issue_val),
        .clear    (div_clr && div_dst == 5'(r)),
        .cnt      (cnt[r])
      );
    end else begin : g_untracked
      assign cnt[r] = 3'd0;
    end
  end

  // A divide issue is only blocked by an older divide that is not finishing this cycle.
  always_comb begin
    haz = 1'b0;
    if (id_use1 && id_src1 != 5'd0 && cnt[id_src1] != 3'd0) haz = 1'b1;
    if (id_use2 && id_src2 != 5'd0 && cnt[id_src2] != 3'd0) haz = 1'b1;
    if (id_wen && id_dst == div_dst && div_busy)             haz = 1'b1;
    if (lat == LAT_DIV && div_busy && !div_done)             haz = 1'b1;
  end

  assign id_stall = id_valid & ~id_flush & (haz | pipe_hold);
  assign id_issue = id_valid & ~id_flush & ~haz & ~pipe_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_busy <= 1'b0;
      div_dst  <= 5'd0;
    end else begin
      if (div_clr) div_busy <= 1'b0;
      if (wr_en && lat == LAT_DIV) begin
        div_busy <= 1'b1;
        div_dst  <= id_dst;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
    end else if (id_stall && !pipe_hold && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Cycle-by-cycle directed bench for decode_hazard_scoreboard: each record is one
// decode cycle with the stall/issue/div_busy values expected before the clock edge.
module tb_decode_hazard_scoreboard;
  import decode_hazard_scoreboard_pkg::*;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       use1;
    logic [4:0] src1;
    logic       use2;
    logic [4:0] src2;
    logic       wen;
    logic [4:0] dst;
    logic [1:0] lat;
    logic       hold;
    logic       flush;
    logic       dd;
    logic       e_stall;
    logic       e_issue;
    logic       e_busy;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        id_valid, id_use1, id_use2, id_wen;
  logic [4:0]  id_src1, id_src2, id_dst;
  logic [1:0]  id_lat;
  logic        pipe_hold, id_flush, div_done;
  logic        id_stall, id_issue, div_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int total = 0;
  int bad = 0;
  int exp_stats = 0;
  vec_t tbl[$];

  decode_hazard_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .id_valid  (id_valid),
    .id_use1   (id_use1),
    .id_src1   (id_src1),
    .id_use2   (id_use2),
    .id_src2   (id_src2),
    .id_wen    (id_wen),
    .id_dst    (id_dst),
    .id_lat    (id_lat),
    .pipe_hold (pipe_hold),
    .id_flush  (id_flush),
    .div_done  (div_done),
    .id_stall  (id_stall),
    .id_issue  (id_issue),
    .div_busy  (div_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(input logic rst, valid, use1, input logic [4:0] src1,
                             input logic use2, input logic [4:0] src2,
                             input logic wen, input logic [4:0] dst, input logic [1:0] lat,
                             input logic hold, flush, dd, e_stall, e_issue, e_busy);
    vec_t t;
    t.rst = rst; t.valid = valid; t.use1 = use1; t.src1 = src1;
    t.use2 = use2; t.src2 = src2; t.wen = wen; t.dst = dst; t.lat = lat;
    t.hold = hold; t.flush = flush; t.dd = dd;
    t.e_stall = e_stall; t.e_issue = e_issue; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver: apply one decode cycle at the falling edge, check before the rising edge
  task automatic run(input vec_t t, input string tag);
    @(negedge clk);
    reset     = t.rst;
    id_valid  = t.valid;
    id_use1   = t.use1;
    id_src1   = t.src1;
    id_use2   = t.use2;
    id_src2   = t.src2;
    id_wen    = t.wen;
    id_dst    = t.dst;
    id_lat    = t.lat;
    pipe_hold = t.hold;
    id_flush  = t.flush;
    div_done  = t.dd;
    #2;
    chk({tag, " id_stall"}, 32'(id_stall), 32'(t.e_stall));
    chk({tag, " id_issue"}, 32'(id_issue), 32'(t.e_issue));
    chk({tag, " div_busy"}, 32'(div_busy), 32'(t.e_busy));
    if (t.e_stall && !t.hold && !t.rst) exp_stats++;
  endtask

  localparam logic [1:0] A = 2'd0;
  localparam logic [1:0] L = 2'd1;
  localparam logic [1:0] M = 2'd2;
  localparam logic [1:0] D = 2'd3;

  initial begin
    reset = 1'b1; id_valid = 0; id_use1 = 0; id_src1 = 0; id_use2 = 0; id_src2 = 0;
    id_wen = 0; id_dst = 0; id_lat = 0; pipe_hold = 0; id_flush = 0; div_done = 0;
    repeat (2) @(negedge clk);

    // reset state: idle outputs, then every register readable without a stall
    run(v(0,0,0,0,0,0,0,0,A,0,0,0, 0,0,0), "reset idle");
    for (int r = 0; r < 32; r++)
      run(v(0,1,1,5'(r),1,5'(r),0,0,A,0,0,0, 0,1,0), $sformatf("reset read r%0d", r));

    // load-use bubble, ALU producer never stalls
    tbl.push_back(v(0,1,1,1,0,0,1,2,L,0,0,0, 0,1,0));
    tbl.push_back(v(0,1,1,2,1,2,1,3,A,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,1,2,1,2,1,3,A,0,0,0, 0,1,0));
    tbl.push_back(v(0,1,1,3,1,3,1,4,A,0,0,0, 0,1,0));
    // mul with pipe_hold in between: counter frozen, two hazard cycles after release
    tbl.push_back(v(0,1,1,1,1,1,1,4,M,0,0,0, 0,1,0));
    tbl.push_back(v(0,1,1,4,0,0,1,5,A,1,0,0, 1,0,0));
    tbl.push_back(v(0,1,1,4,0,0,1,5,A,1,0,0, 1,0,0));
    tbl.push_back(v(0,1,1,4,0,0,1,5,A,1,0,0, 1,0,0));
    tbl.push_back(v(0,1,1,4,0,0,1,5,A,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,1,4,0,0,1,5,A,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,1,4,0,0,1,5,A,0,0,0, 0,1,0));
    // flush with hazard present: no stall, no issue, entry still counts down
    tbl.push_back(v(0,1,1,1,0,0,1,6,M,0,0,0, 0,1,0));
    tbl.push_back(v(0,1,1,6,0,0,1,9,A,0,1,0, 0,0,0));
    tbl.push_back(v(0,1,1,6,0,0,1,9,A,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,1,6,0,0,1,9,A,0,0,0, 0,1,0));
    // dst 0 never tracked, src 0 never hazards
    tbl.push_back(v(0,1,0,0,0,0,1,0,L,0,0,0, 0,1,0));
    tbl.push_back(v(0,1,1,0,1,0,1,10,A,0,0,0, 0,1,0));
    // reset mid-divide with cnt[7]=2, then a stray div_done
    tbl.push_back(v(0,1,0,0,0,0,1,8,D,0,0,0, 0,1,0));
    tbl.push_back(v(0,0,1,8,0,0,1,11,A,0,0,0, 0,0,1));
    tbl.push_back(v(0,1,1,1,0,0,1,7,M,0,0,0, 0,1,1));
    tbl.push_back(v(1,0,0,0,0,0,0,0,A,0,0,0, 0,0,1));
    tbl.push_back(v(0,1,1,7,1,8,1,11,A,0,0,0, 0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,A,0,0,1, 0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,1,9,D,0,0,0, 0,1,0));
    tbl.push_back(v(0,1,1,9,0,0,1,12,A,0,0,1, 1,0,1));
    tbl.push_back(v(0,1,1,9,0,0,1,12,A,0,0,0, 0,1,0));

    foreach (tbl[i]) run(tbl[i], $sformatf("row%0d", i));

    // divide with dependent: ten stall cycles, issue the cycle after div_done
    run(v(0,1,0,0,0,0,1,5,D,0,0,0, 0,1,0), "div5 issue");
    for (int i = 1; i <= 10; i++)
      run(v(0,1,1,5,0,0,1,6,A,0,0,(i == 10), 1,0,1), $sformatf("div5 dep wait%0d", i));
    run(v(0,1,1,5,0,0,1,6,A,0,0,0, 0,1,0), "div5 dep issue");

    // WAW against divide, second divide blocked, done + new divide on one edge
    run(v(0,1,0,0,0,0,1,5,D,0,0,0, 0,1,0), "waw div5");
    for (int i = 0; i < 3; i++)
      run(v(0,1,1,1,0,0,1,5,L,0,0,0, 1,0,1), $sformatf("waw lw5 %0d", i));
    for (int i = 0; i < 2; i++)
      run(v(0,1,1,1,0,0,1,10,D,0,0,0, 1,0,1), $sformatf("waw div10 blk%0d", i));
    run(v(0,1,1,1,0,0,1,10,D,0,0,1, 0,1,1), "waw div10 with done");
    run(v(0,1,1,1,0,0,1,5,L,0,0,0, 0,1,1), "waw lw5 after done");
    run(v(0,1,1,10,0,0,1,11,A,0,0,0, 1,0,1), "waw dep10 wait");
    run(v(0,1,1,10,0,0,1,11,A,0,0,1, 1,0,1), "waw dep10 done");
    run(v(0,1,1,10,0,0,1,11,A,0,0,0, 0,1,0), "waw dep10 issue");

`ifdef HAZARD_STATS_EN
    run(v(0,0,0,0,0,0,0,0,A,0,0,0, 0,0,0), "stats settle");
    chk("stall_cycles", stall_cycles, 32'(exp_stats));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
